axi_delay_multi: RTL and testbench

- Multi-channel, run-time programmable successor to the single-channel AXI handshake delay.
- Sits between two AXI interfaces; used in verification and perf builds to inject handshake latency.
- For each channel (typically AW, W, B, AR, R), it masks out_valid/out_ready for a configurable or pseudo-random number of cycles after in_valid rises.
- Tracks per-channel stall-cycle statistics.

---
 rtl/axi_delay_multi.sv | 132 +++++++++++++
 tb/tb_axi_delay_multi.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_delay_multi.sv
// Multi-channel AXI handshake delay: each channel holds off valid/ready for a
// fixed or LFSR-derived number of cycles after in_valid rises, and counts stalls.

module axi_delay_ch #(
   parameter int DELAY_W = 4,
   parameter int STAT_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DELAY_W-1:0] cfg_delay,
   input  logic               cfg_rand,
   input  logic [DELAY_W-1:0] lfsr_slice,
   input  logic               stat_clear,
   input  logic               in_valid,
   input  logic               in_ready,
   output logic               out_valid,
   output logic               out_ready,
   output logic [STAT_W-1:0]  stat
);
   typedef enum logic [1:0] {IDLE, COUNT, ACTIVE} state_t;

   state_t             state, state_nxt;
   logic [DELAY_W-1:0] cnt, cnt_nxt;
   logic [DELAY_W-1:0] load_d;

   assign load_d = cfg_rand ? (lfsr_slice & cfg_delay) : cfg_delay;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      out_valid = 1'b0;
      out_ready = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (load_d == '0) begin
                  state_nxt = ACTIVE;
               end else begin
                  cnt_nxt   = load_d;
                  state_nxt = COUNT;
               end
            end
         end
         COUNT: begin
            if (!in_valid) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 1'b1;
               if (cnt == DELAY_W'(1)) state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            // Masked by rst so nothing leaks toward either side while resetting.
            out_valid = in_valid & ~rst;
            out_ready = in_ready & ~rst;
            if (!in_valid || in_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || stat_clear) begin
         stat <= '0;
      end else if (state == COUNT && stat != '1) begin
         stat <= stat + 1'b1;
      end
   end
endmodule

module axi_delay_multi #(
   parameter int          NUM_CH    = 5,
   parameter int          DELAY_W   = 4,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          STAT_W    = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CH*DELAY_W-1:0]   cfg_delay,
   input  logic [NUM_CH-1:0]           cfg_rand,
   input  logic                        stat_clear,
   input  logic [NUM_CH-1:0]           in_valid,
   input  logic [NUM_CH-1:0]           in_ready,
   output logic [NUM_CH-1:0]           out_valid,
   output logic [NUM_CH-1:0]           out_ready,
   output logic [NUM_CH*STAT_W-1:0]    stat_stall
);
   logic [15:0] lfsr;

   // Right-shifting Galois form of x^16+x^14+x^13+x^11+1; free-runs out of reset.
   always_ff @(posedge clk) begin
      if (rst) lfsr <= LFSR_SEED;
      else     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam int ROT = (3 * i) % 16;
      logic [DELAY_W-1:0] slice;

      // Each channel sees the LFSR rotated right by a different amount.
      for (genvar b = 0; b < DELAY_W; b++) begin : g_bit
         assign slice[b] = lfsr[(b + ROT) % 16];
      end

      axi_delay_ch #(
         .DELAY_W (DELAY_W),
         .STAT_W  (STAT_W)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .cfg_delay  (cfg_delay[i*DELAY_W +: DELAY_W]),
         .cfg_rand   (cfg_rand[i]),
         .lfsr_slice (slice),
         .stat_clear (stat_clear),
         .in_valid   (in_valid[i]),
         .in_ready   (in_ready[i]),
         .out_valid  (out_valid[i]),
         .out_ready  (out_ready[i]),
         .stat       (stat_stall[i*STAT_W +: STAT_W])
      );
   end
endmodule

// File: tb/tb_axi_delay_multi.sv
// Directed bench for axi_delay_multi: fixed delays, zero delay, aborts,
// saturation, stat_clear priority, mid-run reset and LFSR-driven random delays.

module tb_axi_delay_multi;
   localparam int NC = 5;
   localparam int DW = 4;
   localparam int SW = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [NC*DW-1:0] cfg_delay;
   logic [NC-1:0]    cfg_rand;
   logic             stat_clear;
   logic [NC-1:0]    in_valid;
   logic [NC-1:0]    in_ready;
   logic [NC-1:0]    out_valid;
   logic [NC-1:0]    out_ready;
   logic [NC*SW-1:0] stat_stall;

   int checks   = 0;
   int failures = 0;

   int dseq [NC][0:399];
   int dref [NC][0:19];
   int dcnt [NC];
   int bad;

   axi_delay_multi #(
      .NUM_CH    (NC),
      .DELAY_W   (DW),
      .LFSR_SEED (16'hACE1),
      .STAT_W    (SW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_delay  (cfg_delay),
      .cfg_rand   (cfg_rand),
      .stat_clear (stat_clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .stat_stall (stat_stall)
   );

   always #5 clk = ~clk;

   function automatic int ovb(input int c);
      return int'(out_valid[c]);
   endfunction
   function automatic int orb(input int c);
      return int'(out_ready[c]);
   endfunction
   function automatic int st(input int c);
      return int'(stat_stall[c*SW +: SW]);
   endfunction

   task automatic chk(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Records per-channel delays: a low run of out_valid is the IDLE cycle plus d COUNT cycles.
   task automatic run_rand(input int ncyc);
      int run [NC];
      for (int c = 0; c < NC; c++) begin
         run[c]  = 0;
         dcnt[c] = 0;
      end
      for (int k = 0; k < ncyc; k++) begin
         #1;
         for (int c = 0; c < NC; c++) begin
            if (out_valid[c]) begin
               if (dcnt[c] < 400) dseq[c][dcnt[c]] = run[c] - 1;
               dcnt[c]++;
               run[c] = 0;
            end else begin
               run[c]++;
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic rand_reset();
      rst       = 1'b1;
      cfg_rand  = '1;
      cfg_delay = {NC{4'h7}};
      in_valid  = '1;
      in_ready  = '1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int hits;
      int diff;
      logic [7:0] seen;

      rst        = 1'b1;
      cfg_delay  = '0;
      cfg_rand   = '0;
      stat_clear = 1'b0;
      in_valid   = '0;
      in_ready   = '0;
      repeat (3) @(negedge clk);
      chk("reset_ov", int'(out_valid), 0);
      chk("reset_or", int'(out_ready), 0);
      chk("reset_stat", int'(stat_stall), 0);
      rst = 1'b0;
      #1 chk("post_reset_ov", int'(out_valid), 0);

      // Fixed delay 3 on ch0
      @(negedge clk);
      in_ready           = '1;
      cfg_delay[0*DW+:DW] = 4'd3;
      in_valid[0]        = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk($sformatf("t1_wait%0d", k), ovb(0), 0);
      end
      @(negedge clk);
      chk("t1_active_ov", ovb(0), 1);
      chk("t1_active_or", orb(0), 1);
      in_valid[0] = 1'b0;
      @(negedge clk);
      chk("t1_idle_ov", ovb(0), 0);
      chk("t1_stat", st(0), 3);

      // Zero delay, back-to-back beats on ch1 alternate ACTIVE/IDLE
      cfg_delay[1*DW+:DW] = 4'd0;
      in_valid[1]         = 1'b1;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         chk($sformatf("t2_beat%0d_hi", b), ovb(1), 1);
         @(negedge clk);
         chk($sformatf("t2_beat%0d_lo", b), ovb(1), 0);
      end
      in_valid[1] = 1'b0;
      chk("t2_stat", st(1), 0);

      // Abort after 5 COUNT cycles on ch2, then saturate its counter
      cfg_delay[2*DW+:DW] = 4'd15;
      in_valid[2]         = 1'b1;
      hits = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         hits += ovb(2);
      end
      in_valid[2] = 1'b0;
      @(negedge clk);
      chk("t3_abort_ov", hits + ovb(2), 0);
      chk("t3_abort_stat", st(2), 5);
      in_valid[2] = 1'b1;
      hits = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         hits += ovb(2);
      end
      in_valid[2] = 1'b0;
      chk("t3_one_beat", hits, 1);
      chk("t3_saturate", st(2), 15);
      @(negedge clk);
      @(negedge clk);
      chk("t3_still_sat", st(2), 15);

      // stat_clear zeroes everything, then wins over an increment on ch0
      stat_clear = 1'b1;
      @(negedge clk);
      stat_clear = 1'b0;
      chk("t6_clear_all", int'(stat_stall), 0);
      cfg_delay[0*DW+:DW] = 4'd15;
      in_valid[0]         = 1'b1;
      repeat (10) @(negedge clk);
      chk("t6_pre", st(0), 9);
      stat_clear = 1'b1;
      @(negedge clk);
      stat_clear = 1'b0;
      chk("t6_cleared", st(0), 0);
      @(negedge clk);
      chk("t6_inc1", st(0), 1);
      @(negedge clk);
      chk("t6_inc2", st(0), 2);
      in_valid[0] = 1'b0;
      @(negedge clk);

      // Reset while ch3 counts (counter 6) and ch4 sits in ACTIVE
      cfg_delay[3*DW+:DW] = 4'd9;
      cfg_delay[4*DW+:DW] = 4'd0;
      in_ready[4]         = 1'b0;
      in_valid[3]         = 1'b1;
      in_valid[4]         = 1'b1;
      repeat (4) @(negedge clk);
      chk("t5_pre_ov3", ovb(3), 0);
      chk("t5_pre_ov4", ovb(4), 1);
      chk("t5_pre_stat3", st(3), 3);
      rst                 = 1'b1;
      cfg_delay[3*DW+:DW] = 4'd2;
      #1 chk("t5_rst_mask", int'(out_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t5_first_ov", int'(out_valid), 0);
      chk("t5_first_or", int'(out_ready), 0);
      chk("t5_stat_zero", int'(stat_stall), 0);
      @(negedge clk);
      chk("t5_c1_ov3", ovb(3), 0);
      chk("t5_ch4_ov", ovb(4), 1);
      chk("t5_ch4_or", orb(4), 0);
      @(negedge clk);
      chk("t5_c2_ov3", ovb(3), 0);
      @(negedge clk);
      chk("t5_active_ov3", ovb(3), 1);
      chk("t5_stat3", st(3), 2);
      in_valid = '0;
      @(negedge clk);

      // Random delays on every channel, masked to 0..7
      rand_reset();
      run_rand(2000);
      chk("t4_first_ch0", dseq[0][0], 1);
      chk("t4_first_ch1", dseq[1][0], 4);
      chk("t4_first_ch2", dseq[2][0], 3);
      bad = 0;
      for (int c = 0; c < NC; c++) begin
         seen = '0;
         for (int i = 0; i < dcnt[c] && i < 400; i++) begin
            if (dseq[c][i] < 0 || dseq[c][i] > 7) bad++;
            else seen[dseq[c][i]] = 1'b1;
         end
         chk($sformatf("t4_seen_ch%0d", c), int'(seen), 255);
         for (int i = 0; i < 20; i++) dref[c][i] = dseq[c][i];
      end
      chk("t4_range", bad, 0);
      diff = 0;
      for (int i = 0; i < 20; i++) if (dseq[0][i] != dseq[1][i]) diff++;
      chk("t4_ch_differ", int'(diff != 0), 1);

      rand_reset();
      run_rand(300);
      bad = 0;
      for (int c = 0; c < NC; c++)
         for (int i = 0; i < 20; i++)
            if (dseq[c][i] != dref[c][i]) bad++;
      chk("t4_reproduce", bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
